// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Each operation runs 32 shift steps plus one sign-fix cycle: 33 cycles busy.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a, r_b, r_a_orig, r_acc, r_q, r_hi, r_lo;
  logic               r_is_div, r_neg_q, r_neg_r, r_bzero, r_done;

  logic               w_accept, w_last, w_sa, w_sb, w_div_ok;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo, w_rem;
  logic [WIDTH:0]     w_mul_sum, w_div_sh;
  logic [WIDTH+1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  assign w_accept = (r_state == S_IDLE) && start && !op[2];
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // op[0] marks the signed variants (MULT=1, DIV=3)
  assign w_sa    = op[0] & a[WIDTH-1];
  assign w_sb    = op[0] & b[WIDTH-1];
  assign w_abs_a = w_sa ? -a : a;
  assign w_abs_b = w_sb ? -b : b;

  // Multiply: {acc,q} is the product register, multiplier shifted out of q
  assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_a} : '0);

  // Restoring divide: remainder in acc, dividend shifts out of q as quotient shifts in
  assign w_div_sh   = {r_acc, r_q[WIDTH-1]};
  assign w_div_diff = {1'b0, w_div_sh} - {2'b00, r_b};
  assign w_div_ok   = ~w_div_diff[WIDTH+1];

  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo      = r_neg_q ? -r_q : r_q;
  assign w_rem      = r_neg_r ? -r_acc : r_acc;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_a_orig <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bzero  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a      <= w_abs_a;
            r_b      <= w_abs_b;
            r_a_orig <= a;
            r_is_div <= op[1];
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_bzero  <= (b == '0);
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= op[1] ? w_abs_a : w_abs_b;
          end else if (start && op == 3'd4) begin
            r_hi <= a;
          end else if (start && op == 3'd5) begin
            r_lo <= a;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_is_div) begin
            r_acc <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], w_div_ok};
          end else begin
            {r_acc, r_q} <= {w_mul_sum, r_q[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            if (r_bzero) begin
              r_hi <= r_a_orig;
              r_lo <= '1;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {hi,lo} queued at issue, popped at done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_hi = '0, last_lo = '0;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    logic signed [63:0] sp;
    logic [31:0] qq, rr;
    p = '0;
    case (o)
      3'd0: p = {32'b0, x} * {32'b0, y};
      3'd1: begin
        sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        p  = sp;
      end
      3'd2: p = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      3'd3: begin
        if (y == 0) p = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
        else begin
          qq = $signed(x) / $signed(y);
          rr = $signed(x) % $signed(y);
          p  = {rr, qq};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp, input bit push);
    start = 1'b1; op = o; a = x; b = y;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom_range(0, 3)); a = $urandom; b = $urandom;
    cyc = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL issue_busy: busy=%b required 1", busy); end
  endtask

  task automatic wait_done(input string name);
    logic [63:0] exp;
    bit seen;
    seen = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (done === 1'b1) seen = 1;
      else begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: busy=%b required 1 at cycle %0d", name, busy, cyc); end
      end
    end
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 64'hx;
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s_timeout: no done within %0d cycles", name, cyc);
    end else begin
      checks++;
      if (cyc != 33) begin errors++; $display("FAIL %s_latency: done at cycle %0d required 33", name, cyc); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_done: busy=%b required 0", name, busy); end
      if ({hi, lo} !== exp) begin errors++; $display("FAIL %s_result: hi=%h lo=%h required hi=%h lo=%h", name, hi, lo, exp[63:32], exp[31:0]); end
    end
    {last_hi, last_lo} = exp;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: %b required 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: %h required 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: %h required 0", lo); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multu;
    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, 1);
    wait_done("multu_max");
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_width: done=%b required 0", done); end
    checks++; if ({hi, lo} !== {last_hi, last_lo}) begin errors++; $display("FAIL multu_hold: hi=%h lo=%h required %h %h", hi, lo, last_hi, last_lo); end
  endtask

  task automatic test_back_to_back;
    issue(3'd1, 32'hFFFFFFFD, 32'd7, {32'hFFFFFFFF, 32'hFFFFFFEB}, 1);
    wait_done("mult_neg");
    issue(3'd2, 32'd7, 32'd2, {32'd1, 32'd3}, 1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_width: done=%b required 0", done); end
    wait_done("divu_b2b");
  endtask

  task automatic test_div;
    issue(3'd3, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1);
    wait_done("div_neg_a");
    issue(3'd3, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 1);
    wait_done("div_neg_b");
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 1);
    wait_done("div_ovf");
  endtask

  task automatic test_divzero;
    issue(3'd2, 32'h12345678, 32'd0, {32'h12345678, 32'hFFFFFFFF}, 1);
    wait_done("divu_zero");
    issue(3'd3, 32'hFFFFFFF9, 32'd0, {32'hFFFFFFF9, 32'hFFFFFFFF}, 1);
    wait_done("div_zero");
  endtask

  task automatic test_ignore_abort;
    issue(3'd0, 32'd5, 32'd6, {32'd0, 32'd30}, 1);
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; cyc++; end
    start = 1'b1; op = 3'd4; a = 32'hDEAD;
    @(posedge clk); #1; cyc++;
    start = 1'b0;
    wait_done("busy_ignore");
    issue(3'd0, 32'd5, 32'd6, 64'h0, 0);
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: %b required 0", busy); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL abort_hilo: hi=%h lo=%h required 0", hi, lo); end
    #2 rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_quiet: done=%b busy=%b required 0 0", done, busy); end
    end
    issue(3'd0, 32'd3, 32'd4, {32'd0, 32'd12}, 1);
    wait_done("after_abort");
  endtask

  task automatic test_mthi_mtlo;
    start = 1'b1; op = 3'd4; a = 32'hDEADBEEF; b = '0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if ({hi, lo} !== {32'hDEADBEEF, last_lo}) begin errors++; $display("FAIL mthi: hi=%h lo=%h required %h %h", hi, lo, 32'hDEADBEEF, last_lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_flags: busy=%b done=%b required 0 0", busy, done); end
    start = 1'b1; op = 3'd5; a = 32'h0BADF00D;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if ({hi, lo} !== {32'hDEADBEEF, 32'h0BADF00D}) begin errors++; $display("FAIL mtlo: hi=%h lo=%h required deadbeef 0badf00d", hi, lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_flags: busy=%b done=%b required 0 0", busy, done); end
    start = 1'b1; op = 3'd6; a = 32'h11111111;
    @(posedge clk); #1;
    op = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if ({hi, lo} !== {32'hDEADBEEF, 32'h0BADF00D} || busy !== 1'b0) begin errors++; $display("FAIL nop: hi=%h lo=%h busy=%b required deadbeef 0badf00d 0", hi, lo, busy); end
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 10; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i % 3 == 1) y = y >> 20;
      issue(o, x, y, model(o, x, y), 1);
      wait_done("random");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    test_reset;
    test_multu;
    test_back_to_back;
    test_div;
    test_divzero;
    test_ignore_abort;
    test_mthi_mtlo;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
